// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 5-9 data bits, none/odd/even parity, 1-2 stop bits.
// Received words are held on a ready/valid port with per-word error flags and an overrun pulse.
//
// state         | meaning
// --------------+-------------------------------------------------------------
// ST_IDLE       | line idle, waiting for a synchronised high->low edge
// ST_START      | voting the start bit; a vote of 1 is a glitch
// ST_DATA       | shifting in data bits, LSB first
// ST_PARITY     | voting the parity bit (only when PARITY != 0)
// ST_STOP       | voting stop bit(s); the last vote completes the frame
// ST_BREAK_WAIT | break seen, waiting for the line to return high
module uart_rx_param #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int TICK = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int SW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_LOAD = TW'(TICK - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [0:0]    STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit            PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 rx_prev;
  logic [TW-1:0]        tick_cnt;
  logic [SW-1:0]        samp_cnt;
  logic [SW-1:0]        samp_nxt;
  logic                 strobe;
  logic                 running;
  logic                 s_a, s_b;
  logic                 vote;
  logic                 vote_cycle;
  logic [DATA_BITS-1:0] shift_q;
  logic [BW-1:0]        bit_cnt;
  logic [0:0]           stop_cnt;
  logic                 ferr_q, perr_q;
  logic                 par_bad;
  logic                 is_break;
  logic                 restart, shift_en, par_chk, stop_chk, complete;

  // Synchroniser and edge-detect history idle high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], serial_in};
      rx_prev <= sync_q[1];
    end
  end

  assign rx_s = sync_q[1];

  assign running    = (state != ST_IDLE) && (state != ST_BREAK_WAIT);
  assign strobe     = (tick_cnt == '0);
  assign samp_nxt   = (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + SW'(1);
  assign vote_cycle = running && strobe && (samp_nxt == SAMP_C);
  assign vote       = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
  assign par_bad    = (^shift_q) ^ vote ^ PAR_ODD;
  assign is_break   = !vote && (shift_q == '0);

  // Sample k of a bit lands k*TICK clocks after the bit edge, so the vote window is centred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
      s_a      <= 1'b0;
      s_b      <= 1'b0;
    end else if (restart) begin
      tick_cnt <= TICK_LOAD;
      samp_cnt <= '0;
    end else if (running) begin
      if (strobe) begin
        tick_cnt <= TICK_LOAD;
        samp_cnt <= samp_nxt;
        if (samp_nxt == SAMP_A) s_a <= rx_s;
        if (samp_nxt == SAMP_B) s_b <= rx_s;
      end else begin
        tick_cnt <= tick_cnt - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    stop_chk  = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          restart   = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (vote_cycle) state_nxt = vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (vote_cycle) begin
          shift_en = 1'b1;
          if (bit_cnt == DATA_LAST) state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (vote_cycle) begin
          par_chk   = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (vote_cycle) begin
          stop_chk = 1'b1;
          if (stop_cnt == STOP_LAST) begin
            complete  = 1'b1;
            state_nxt = is_break ? ST_BREAK_WAIT : ST_IDLE;
          end
        end
      end
      ST_BREAK_WAIT: begin
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      if (restart) begin
        shift_q  <= '0;
        bit_cnt  <= '0;
        stop_cnt <= '0;
        ferr_q   <= 1'b0;
        perr_q   <= 1'b0;
      end
      if (shift_en) begin
        shift_q <= {vote, shift_q[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (par_chk) perr_q <= par_bad;
      if (stop_chk) begin
        if (!vote) ferr_q <= 1'b1;
        stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

  // A held word wins over a new one unless the consumer takes it on this very edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_err      <= 1'b0;
      parity_err     <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!data_out_valid || data_out_ready) begin
          data_out       <= shift_q;
          frame_err      <= ferr_q | ~vote;
          parity_err     <= perr_q;
          data_out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 7N2) driven by bit-timed serial frames.
module tb_uart_rx_param;

  localparam int BAUD_NS = 8681;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_ap, rst_7;
  logic       ser_a, ser_p, ser_7;
  logic       ready_a, ready_p, ready_7;
  logic [7:0] data_a, data_p;
  logic [6:0] data_7;
  logic       valid_a, valid_p, valid_7;
  logic       fe_a, fe_p, fe_7;
  logic       pe_a, pe_p, pe_7;
  logic       ov_a, ov_p, ov_7;

  int checks = 0;
  int errors = 0;

  int acc_a = 0, acc_p = 0, acc_7 = 0;
  int ovc_a = 0, ovc_p = 0, ovc_7 = 0;
  logic [7:0] last_a = '0, last_p = '0;
  logic [6:0] last_7 = '0;
  logic lfe_a = 1'b0, lfe_p = 1'b0, lfe_7 = 1'b0;
  logic lpe_a = 1'b0, lpe_p = 1'b0, lpe_7 = 1'b0;

  uart_rx_param dut_a (
    .clk(clk), .rst(rst_ap), .serial_in(ser_a),
    .data_out(data_a), .data_out_valid(valid_a), .data_out_ready(ready_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
  );

  uart_rx_param #(.PARITY(2)) dut_p (
    .clk(clk), .rst(rst_ap), .serial_in(ser_p),
    .data_out(data_p), .data_out_valid(valid_p), .data_out_ready(ready_p),
    .frame_err(fe_p), .parity_err(pe_p), .overrun(ov_p)
  );

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) dut_7 (
    .clk(clk), .rst(rst_7), .serial_in(ser_7),
    .data_out(data_7), .data_out_valid(valid_7), .data_out_ready(ready_7),
    .frame_err(fe_7), .parity_err(pe_7), .overrun(ov_7)
  );

  // Handshakes complete on the next posedge; inputs only change #1 after a posedge.
  always @(negedge clk) begin
    if (valid_a && ready_a) begin acc_a++; last_a = data_a; lfe_a = fe_a; lpe_a = pe_a; end
    if (valid_p && ready_p) begin acc_p++; last_p = data_p; lfe_p = fe_p; lpe_p = pe_p; end
    if (valid_7 && ready_7) begin acc_7++; last_7 = data_7; lfe_7 = fe_7; lpe_7 = pe_7; end
    if (ov_a) ovc_a++;
    if (ov_p) ovc_p++;
    if (ov_7) ovc_7++;
  end

  task automatic set_line(input int sel, input logic b);
    case (sel)
      0:       ser_a = b;
      1:       ser_p = b;
      default: ser_7 = b;
    endcase
  endtask

  task automatic idle_bits(input int n);
    #(n * BAUD_NS);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data, input int ndata,
                            input bit has_par, input logic par_bit,
                            input logic stop_val, input int nstop);
    set_line(sel, 1'b0);
    #(BAUD_NS);
    for (int i = 0; i < ndata; i++) begin
      set_line(sel, data[i]);
      #(BAUD_NS);
    end
    if (has_par) begin
      set_line(sel, par_bit);
      #(BAUD_NS);
    end
    for (int i = 0; i < nstop; i++) begin
      set_line(sel, stop_val);
      #(BAUD_NS);
    end
    set_line(sel, 1'b1);
  endtask

  task automatic test_reset();
    rst_ap = 1'b0; rst_7 = 1'b0;
    ser_a = 1'b1; ser_p = 1'b1; ser_7 = 1'b1;
    ready_a = 1'b1; ready_p = 1'b1; ready_7 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({valid_a, data_a, fe_a, pe_a, ov_a} !== 12'h000) begin
      errors++;
      $display("FAIL reset_a got v=%b d=%h fe=%b pe=%b ov=%b exp all 0", valid_a, data_a, fe_a, pe_a, ov_a);
    end
    checks++;
    if ({valid_p, data_p, fe_p, pe_p, ov_p} !== 12'h000) begin
      errors++;
      $display("FAIL reset_p got v=%b d=%h fe=%b pe=%b ov=%b exp all 0", valid_p, data_p, fe_p, pe_p, ov_p);
    end
    checks++;
    if ({valid_7, data_7, fe_7, pe_7, ov_7} !== 11'h000) begin
      errors++;
      $display("FAIL reset_7 got v=%b d=%h fe=%b pe=%b ov=%b exp all 0", valid_7, data_7, fe_7, pe_7, ov_7);
    end
    @(negedge clk);
    rst_ap = 1'b1; rst_7 = 1'b1;
    idle_bits(1);
  endtask

  task automatic test_basic();
    int a0, o0;
    a0 = acc_a; o0 = ovc_a;
    send_frame(0, 9'h061, 8, 1'b0, 1'b0, 1'b1, 1);
    idle_bits(1);
    checks++;
    if (acc_a - a0 != 1) begin errors++; $display("FAIL basic_count got %0d exp 1", acc_a - a0); end
    checks++;
    if (last_a !== 8'h61) begin errors++; $display("FAIL basic_data got %h exp 61", last_a); end
    checks++;
    if (lfe_a !== 1'b0 || lpe_a !== 1'b0) begin
      errors++; $display("FAIL basic_flags got fe=%b pe=%b exp 0 0", lfe_a, lpe_a);
    end
    checks++;
    if (ovc_a != o0) begin errors++; $display("FAIL basic_overrun got %0d exp 0", ovc_a - o0); end
    checks++;
    if (valid_a !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", valid_a); end
  endtask

  task automatic test_parity();
    int a0;
    a0 = acc_p;
    send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1'b1, 1);
    idle_bits(1);
    checks++;
    if (acc_p - a0 != 1 || last_p !== 8'h07 || lpe_p !== 1'b1 || lfe_p !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad got n=%0d d=%h pe=%b fe=%b exp n=1 d=07 pe=1 fe=0", acc_p - a0, last_p, lpe_p, lfe_p);
    end
    send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1'b1, 1);
    idle_bits(1);
    checks++;
    if (acc_p - a0 != 2 || last_p !== 8'h07 || lpe_p !== 1'b0 || lfe_p !== 1'b0) begin
      errors++;
      $display("FAIL parity_good got n=%0d d=%h pe=%b fe=%b exp n=2 d=07 pe=0 fe=0", acc_p - a0, last_p, lpe_p, lfe_p);
    end
    checks++;
    if (ovc_p != 0) begin errors++; $display("FAIL parity_overrun got %0d exp 0", ovc_p); end
  endtask

  task automatic test_frame_break();
    int a0;
    a0 = acc_a;
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b0, 1);
    idle_bits(2);
    checks++;
    if (acc_a - a0 != 1 || last_a !== 8'h55 || lfe_a !== 1'b1 || lpe_a !== 1'b0) begin
      errors++;
      $display("FAIL frame_err got n=%0d d=%h fe=%b pe=%b exp n=1 d=55 fe=1 pe=0", acc_a - a0, last_a, lfe_a, lpe_a);
    end
    set_line(0, 1'b0);
    idle_bits(20);
    checks++;
    if (acc_a - a0 != 2 || last_a !== 8'h00 || lfe_a !== 1'b1) begin
      errors++;
      $display("FAIL break_word got n=%0d d=%h fe=%b exp n=2 d=00 fe=1", acc_a - a0, last_a, lfe_a);
    end
    set_line(0, 1'b1);
    idle_bits(3);
    checks++;
    if (acc_a - a0 != 2) begin errors++; $display("FAIL break_retrigger got n=%0d exp 2", acc_a - a0); end
  endtask

  task automatic test_glitch();
    int a0;
    a0 = acc_a;
    set_line(0, 1'b0);
    #3000;
    set_line(0, 1'b1);
    idle_bits(12);
    checks++;
    if (acc_a != a0 || valid_a !== 1'b0) begin
      errors++; $display("FAIL glitch_word got n=%0d v=%b exp n=0 v=0", acc_a - a0, valid_a);
    end
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1);
    idle_bits(1);
    checks++;
    if (acc_a - a0 != 1 || last_a !== 8'hA5 || lfe_a !== 1'b0) begin
      errors++;
      $display("FAIL glitch_after got n=%0d d=%h fe=%b exp n=1 d=a5 fe=0", acc_a - a0, last_a, lfe_a);
    end
  endtask

  task automatic test_back_to_back();
    int a0, o0;
    @(posedge clk); #1 ready_a = 1'b0;
    a0 = acc_a; o0 = ovc_a;
    send_frame(0, 9'h061, 8, 1'b0, 1'b0, 1'b1, 1);
    send_frame(0, 9'h062, 8, 1'b0, 1'b0, 1'b1, 1);
    idle_bits(1);
    checks++;
    if (valid_a !== 1'b1 || data_a !== 8'h61) begin
      errors++; $display("FAIL b2b_hold got v=%b d=%h exp v=1 d=61", valid_a, data_a);
    end
    checks++;
    if (ovc_a - o0 != 1) begin errors++; $display("FAIL b2b_overrun got %0d cycles exp 1", ovc_a - o0); end
    checks++;
    if (acc_a != a0) begin errors++; $display("FAIL b2b_no_accept got n=%0d exp 0", acc_a - a0); end
    @(posedge clk); #1 ready_a = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (acc_a - a0 != 1 || last_a !== 8'h61 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got n=%0d d=%h v=%b exp n=1 d=61 v=0", acc_a - a0, last_a, valid_a);
    end
    idle_bits(2);
    checks++;
    if (acc_a - a0 != 1) begin errors++; $display("FAIL b2b_dropped got n=%0d exp 1", acc_a - a0); end
  endtask

  task automatic test_reset_midframe();
    int a0, o0;
    a0 = acc_7; o0 = ovc_7;
    send_frame(2, 9'h03F, 7, 1'b0, 1'b0, 1'b1, 2);
    idle_bits(1);
    checks++;
    if (valid_7 !== 1'b1 || data_7 !== 7'h3F || fe_7 !== 1'b0) begin
      errors++; $display("FAIL m7_first got v=%b d=%h fe=%b exp v=1 d=3f fe=0", valid_7, data_7, fe_7);
    end
    set_line(2, 1'b0);
    #(BAUD_NS);
    set_line(2, 1'b1);
    #(3 * BAUD_NS);
    @(posedge clk); #1 rst_7 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid_7, data_7, fe_7, pe_7, ov_7} !== 11'h000) begin
      errors++;
      $display("FAIL m7_in_reset got v=%b d=%h fe=%b pe=%b ov=%b exp all 0", valid_7, data_7, fe_7, pe_7, ov_7);
    end
    repeat (3) @(posedge clk);
    #1 rst_7 = 1'b1; ready_7 = 1'b1;
    idle_bits(1);
    checks++;
    if (acc_7 != a0 || valid_7 !== 1'b0) begin
      errors++; $display("FAIL m7_aborted got n=%0d v=%b exp n=0 v=0", acc_7 - a0, valid_7);
    end
    send_frame(2, 9'h012, 7, 1'b0, 1'b0, 1'b1, 2);
    idle_bits(1);
    checks++;
    if (acc_7 - a0 != 1 || last_7 !== 7'h12 || lfe_7 !== 1'b0 || lpe_7 !== 1'b0) begin
      errors++;
      $display("FAIL m7_after got n=%0d d=%h fe=%b pe=%b exp n=1 d=12 fe=0 pe=0", acc_7 - a0, last_7, lfe_7, lpe_7);
    end
    checks++;
    if (ovc_7 != o0) begin errors++; $display("FAIL m7_overrun got %0d exp 0", ovc_7 - o0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_break();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
